// File: rtl/pci_pkg.sv
// pci_pkg: shared bus command codes, target state encoding and default window base.
package pci_pkg;
    localparam logic [3:0] CMD_MEM_READ = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_1000;
    typedef enum logic [2:0] {
        T_IDLE,
        T_DEV,
        T_WAIT,
        T_DATA,
        T_STOP,
        T_TURN,
        T_BUSY
    } tgt_state_t;
endpackage

// File: rtl/pci_target_mem.sv
// pci_target_mem: DEPTH x 32 register file, async clear, byte-enable write, combinational read.
module pci_target_mem #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            mem <= '{default: '0};
        else if (we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pci_target.sv
// pci_target: PCI memory target serving a DEPTH-word register window at BASE_ADDR.
// Define PCI_TGT_STOP_EN to disconnect bursts with STOP# at the last window word instead of wrapping.
module pci_target
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int DEPTH = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_n,
    input  logic        irdy_n,
    input  logic [3:0]  cbe_n,
    input  logic [31:0] ad_in,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic        devsel_n,
    output logic        trdy_n,
    output logic        stop_n
);
    localparam int AW = $clog2(DEPTH);
`ifdef PCI_TGT_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    tgt_state_t    state;
    logic          frame_prev;
    logic          is_wr;
    logic          hit;
    logic          beat;
    logic [2:0]    cnt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_inc;
    logic [AW-1:0] raddr;
    logic [31:0]   rd_data;

    always_comb begin
        hit = ad_in[31:AW+2] == BASE_ADDR[31:AW+2] && (cbe_n == CMD_MEM_READ || cbe_n == CMD_MEM_WRITE);
        beat = state == T_DATA && !irdy_n && !trdy_n;
        idx_inc = idx + AW'(1);
        raddr = beat ? idx_inc : idx;
    end

    pci_target_mem #(.DEPTH(DEPTH)) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (beat && is_wr),
        .be   (~cbe_n),
        .waddr(idx),
        .wdata(ad_in),
        .raddr(raddr),
        .rdata(rd_data)
    );

    // ad_out always carries the word the next TRDY# beat will present
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= T_IDLE;
            frame_prev <= 1'b0;
            is_wr <= 1'b0;
            cnt <= '0;
            idx <= '0;
            devsel_n <= 1'b1;
            trdy_n <= 1'b1;
            stop_n <= 1'b1;
            ad_oe <= 1'b0;
            ad_out <= '0;
        end else begin
            frame_prev <= frame_n;
            ad_out <= rd_data;
            case (state)
                T_IDLE: if (!frame_n && frame_prev) begin
                    idx <= ad_in[AW+1:2];
                    is_wr <= cbe_n == CMD_MEM_WRITE;
                    state <= hit ? T_DEV : T_BUSY;
                end
                T_DEV: begin
                    devsel_n <= 1'b0;
                    ad_oe <= !is_wr;
                    if (WAIT_STATES == 0) begin
                        state <= T_DATA;
                        trdy_n <= 1'b0;
                        stop_n <= !(STOP_EN && &idx && !frame_n);
                    end else begin
                        state <= T_WAIT;
                        cnt <= 3'(WAIT_STATES - 1);
                    end
                end
                T_WAIT: if (cnt == '0) begin
                    state <= T_DATA;
                    trdy_n <= 1'b0;
                    stop_n <= !(STOP_EN && &idx && !frame_n);
                end else begin
                    cnt <= cnt - 3'd1;
                end
                T_DATA: if (beat) begin
                    idx <= idx_inc;
                    if (frame_n) begin
                        state <= T_TURN;
                        devsel_n <= 1'b1;
                        trdy_n <= 1'b1;
                        stop_n <= 1'b1;
                        ad_oe <= 1'b0;
                    end else if (STOP_EN && &idx) begin
                        state <= T_STOP;
                        trdy_n <= 1'b1;
                        ad_oe <= 1'b0;
                    end else begin
                        stop_n <= !(STOP_EN && &idx_inc);
                    end
                end
                T_STOP: if (frame_n) begin
                    state <= T_TURN;
                    devsel_n <= 1'b1;
                    trdy_n <= 1'b1;
                    stop_n <= 1'b1;
                    ad_oe <= 1'b0;
                end
                T_TURN: state <= T_IDLE;
                T_BUSY: if (frame_n && irdy_n) state <= T_IDLE;
                default: state <= T_IDLE;
            endcase
        end
    end
endmodule

// File: doc/pci_target.md
Name: pci_target

Overview:
- Responder end of the team's PCI bus.
- Decodes address phases, claims hits with DEVSEL#, and paces data phases with TRDY#.
- Serves single and burst memory read/write from an internal register-file window.
- Sits on the same frame/irdy/trdy/devsel bus that the bus-phase tracker observes; a bench initiator drives the master side.

Parameters:
- BASE_ADDR, 32'h0000_1000: byte base of window. Must be aligned to 4*DEPTH.
- DEPTH, 16: number of 32-bit words in the window. Power of two, 2..256.
- WAIT_STATES, 1: clocks between DEVSEL# assertion and first TRDY# assertion, 0..7.

Ports:
- clk  in  1  bus clock. All sequential logic on negedge clk, matching bus timing.
- rst  in  1  reset, asynchronous, active-high.
- frame_n  in  1  FRAME#, active-low.
- irdy_n  in  1  IRDY#, active-low.
- cbe_n  in  4  command during address phase; byte enables (active-low) during data phases.
- ad_in  in  32  AD bus sampled value.
- ad_out  out  32  read data.
- ad_oe  out  1  AD output enable.
- devsel_n  out  1  DEVSEL#, active-low.
- trdy_n  out  1  TRDY#, active-low.
- stop_n  out  1  STOP#, active-low.

Behaviour:
- Reset values (asynchronous):
  - devsel_n=1, trdy_n=1, stop_n=1, ad_oe=0, ad_out=0.
  - State T_IDLE, all memory words 0.
  - frame_prev=0. A FRAME# already low at reset release is not treated as a new start.
- States:
  - T_IDLE, T_DEV, T_WAIT, T_DATA, T_STOP, T_TURN, T_BUSY.
  - State encoding is a 3-bit enum.
- Address phase: detected in T_IDLE on an edge sampling frame_n=0 with frame_prev=1.
  - Latch addr=ad_in and cmd=cbe_n.
  - Hit condition: addr[31:log2(DEPTH)+2] equals the same bits of BASE_ADDR, and cmd is 4'b0110 (mem read) or 4'b0111 (mem write).
  - idx = addr[log2(DEPTH)+1:2]. addr[1:0] is ignored.
  - Hit -> T_DEV. Miss -> T_BUSY.
- T_DEV (turnaround, one clock):
  - devsel_n=0.
  - Reads: ad_oe=1.
  - Next state: T_WAIT if WAIT_STATES>0, else T_DATA.
- T_WAIT: devsel_n=0, trdy_n=1. Counts WAIT_STATES clocks, then T_DATA.
- T_DATA: trdy_n=0.
  - Reads: ad_out=mem[idx], valid whenever trdy_n=0.
  - A beat transfers on an edge sampling irdy_n=0 with trdy_n=0. With irdy_n=1 the state holds and no transfer occurs.
  - Write beat: each byte b of mem[idx] is updated from ad_in where cbe_n[b]=0.
  - After each beat, idx increments (mod DEPTH). Subsequent beats have zero wait states.
  - Beat with frame_n=1 (final) -> T_TURN.
- T_TURN (one clock):
  - devsel_n, trdy_n, stop_n deasserted; ad_oe=0.
  - Then T_IDLE.
- T_BUSY: non-claimed transaction. Wait for frame_n=1 and irdy_n=1, then T_IDLE.
- Burst crossing window end without the macro: idx wraps to 0.
- Simultaneous final beat and window-end: final beat takes priority, giving a normal T_TURN with no STOP#.
- Reset mid-transaction: drivers release immediately, state returns to T_IDLE, the remainder of that transaction is ignored, and memory is cleared.
- Master abort is not modelled; the bench must not drive data without DEVSEL#.

Optional Feature:
- Macro: PCI_TGT_STOP_EN.
- Defined: on a beat transferring word DEPTH-1 with frame_n=0:
  - stop_n=0 is asserted alongside trdy_n=0 for that beat (disconnect-with-data).
  - Then T_STOP: trdy_n=1, devsel_n=0, stop_n=0, ad_oe=0, until an edge sampling frame_n=1, then T_TURN.
- Undefined: stop_n is tied to 1, T_STOP is unreachable, and idx wraps.

Decomposition:
- Package pci_pkg holds:
  - Command constants CMD_MEM_READ=4'b0110 and CMD_MEM_WRITE=4'b0111.
  - Target state enum.
  - Default BASE_ADDR.
- Natural sub-module: pci_target_mem. It is a DEPTH x 32 register file with async clear, byte-enable write port, and combinational read port.

Test Plan:
- Single write: addr 0x1004, cmd 0111, data 0xDEADBEEF, cbe_n=0000, WAIT_STATES=1.
  - devsel_n low 1 clock after address phase; trdy_n low 1 clock later.
  - mem[1]=0xDEADBEEF afterwards.
- Read-back: addr 0x1004, cmd 0110.
  - ad_oe=1 from T_DEV; ad_out=0xDEADBEEF while trdy_n=0.
  - Signals release in T_TURN.
- Byte enables: write 0x11223344 to 0x1008 with cbe_n=1010 over prior 0 -> mem[2]=0x00220044.
- Burst with IRDY# stalls: 4-beat write from 0x1000 with irdy_n=1 on beat 2 for 2 clocks.
  - Exactly 4 words written, mem[0..3] correct, no double write.
- Miss: addr 0x2000 or cmd 0010 -> devsel_n, trdy_n, ad_oe stay inactive; target returns to T_IDLE after bus idle.
- Window end: 3-beat write from 0x103C.
  - Macro off: mem[15], mem[0], mem[1] written.
  - Macro on: stop_n=0 on first beat, only mem[15] written, T_STOP held until frame_n=1.
